// File: rtl/skid_pkg.sv
`default_nettype none
// ============================================================================
// skid_pkg -- shared state encoding and default sizes for the skid stage
// Rev 1.0
// ============================================================================
package skid_pkg;

    localparam int SKID_WIDTH = 32;
    localparam int SKID_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage
`default_nettype wire

// File: rtl/flopenr32.sv
`default_nettype none
// ============================================================================
// flopenr32 -- enabled data register, synchronous active-low clear to zero
// Rev 1.0
// ============================================================================
module flopenr32
    import skid_pkg::*;
#(
    parameter int WIDTH = SKID_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/skid_reg32.sv
`default_nettype none
// ============================================================================
// skid_reg32 -- two-entry valid/ready skid stage with a registered in_ready
// Optional stall counter enabled by defining STALL_CNT_EN.  Rev 1.0
// ============================================================================
module skid_reg32
    import skid_pkg::*;
#(
    parameter int WIDTH = SKID_WIDTH,
    parameter int CNT_W = SKID_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    skid_state_t      state;
    logic             accept;
    logic             pop;
    logic             en_out;
    logic             en_skid;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] out_next;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // Data registers are frozen during flush so a word accepted then never surfaces.
    assign en_out  = !flush && (((state == EMPTY) && accept) ||
                                ((state == BUSY) && accept && pop) ||
                                ((state == FULL) && pop));
    assign en_skid = !flush && (state == BUSY) && accept && !pop;

    assign out_next = (state == FULL) ? skid_data : in_data;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= BUSY;
                        out_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && !pop) begin
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (pop && !accept) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state    <= BUSY;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    flopenr32 #(.WIDTH(WIDTH)) u_out_reg (
        .clk (clk),
        .rst (rst),
        .en  (en_out),
        .d   (out_next),
        .q   (out_data)
    );

    flopenr32 #(.WIDTH(WIDTH)) u_skid_reg (
        .clk (clk),
        .rst (rst),
        .en  (en_skid),
        .d   (in_data),
        .q   (skid_data)
    );

`ifdef STALL_CNT_EN
    // Saturating; flush intentionally leaves the count alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_skid_reg32.sv
`default_nettype none
// Bench for skid_reg32: directed steps plus random traffic against a queue model.
module tb_skid_reg32;

    localparam int W  = 32;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
`ifdef STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] m_last = '0;
    int           m_cnt  = 0;

    always #5 clk = ~clk;

    skid_reg32 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("out_data", out_data, m_last);
`ifdef STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
    endtask

    // One clock: drive inputs, advance the queue model at the edge, then compare.
    task automatic cyc(input logic r, input logic fl, input logic iv,
                       input logic [W-1:0] d, input logic ordy);
        bit acc;
        bit pp;
        rst       = r;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        acc = iv && (mq.size() < 2);
        pp  = (mq.size() > 0) && ordy;
        if (!r) begin
            mq.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            if ((mq.size() > 0) && !ordy && (m_cnt < (1 << CW) - 1)) m_cnt++;
            if (fl) begin
                mq.delete();
            end else begin
                if (pp) void'(mq.pop_front());
                if (acc) mq.push_back(d);
            end
        end
        if (mq.size() > 0) m_last = mq[0];
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset with a live producer
        cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Streaming at full rate
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 32'(k), 1'b1);
            chk("stream_data", out_data, 32'(k));
            chk("stream_in_ready", 32'(in_ready), 32'h1);
        end
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Backpressure fills the skid register
        cyc(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        chk("bp_full_in_ready", 32'(in_ready), 32'h0);
        chk("bp_hold_data", out_data, 32'hA);
        cyc(1'b1, 1'b0, 1'b1, 32'hE, 1'b0);
        chk("bp_still_a", out_data, 32'hA);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("bp_second", out_data, 32'hB);
        chk("bp_ready_back", 32'(in_ready), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("bp_drained", 32'(out_valid), 32'h0);

        // Flush while full, with a word offered
        cyc(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'hC, 1'b0);
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_ready", 32'(in_ready), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("flush_no_c", 32'(out_data == 32'hC), 32'h0);

        // Reset while busy
        cyc(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("midrst_data", out_data, 32'h0);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 32'h66, 1'b0);
        chk("midrst_next", out_data, 32'h66);

        // Sustained stall saturates the counter
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
`ifdef STALL_CNT_EN
        chk("stall_sat", 32'(stall_cnt), 32'd15);
`endif
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
`ifdef STALL_CNT_EN
        chk("stall_flush", 32'(stall_cnt), 32'd15);
`endif
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
`ifdef STALL_CNT_EN
        chk("stall_rst", 32'(stall_cnt), 32'd0);
`endif

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 99) != 0),
                1'($urandom_range(0, 31) == 0),
                1'($urandom_range(0, 3) != 0),
                32'($urandom),
                1'($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
